network_rx_pad_strip: RTL and testbench
=======================================

// Module: network_rx_pad_strip
// PURPOSE
// RX-side counterpart of the TX Ethernet frame padder: strips Ethernet minimum-size padding from received frames.
// Sits between the RX backpressure-drop stage and the RX FIFO in the network module, on the CMAC user clock.
// For IPv4 frames it trims tkeep/tlast to exactly 14 + IPv4 total_length bytes and swallows any trailing beats.
// All other frames pass unchanged. Two saturating statistics counters are exported.
// PARAMETERS
// DATA_BITS   512  AXI4S data width; keep width is DATA_BITS/8 (fixed 512 in this build)
// CNT_BITS    32   width of statistics counters
// EN_STRIP    1    0: pure pass-through register stage, no trimming, counters stay 0
// PORTS
// aclk           in   1          CMAC user clock (rclk domain)
// aresetn        in   1          asynchronous active-low reset
// s_axis_tvalid  in   1          RX stream in (AXI4S slave)
// s_axis_tready  out  1
// s_axis_tdata   in   512        byte 0 = tdata[7:0], network byte order
// s_axis_tkeep   in   64         contiguous from bit 0
// s_axis_tlast   in   1
// m_axis_tvalid  out  1          RX stream out (AXI4S master)
// m_axis_tready  in   1
// m_axis_tdata   out  512
// m_axis_tkeep   out  64
// m_axis_tlast   out  1
// trim_cnt       out  CNT_BITS   frames whose keep/length was reduced (saturating)
// short_cnt      out  CNT_BITS   IPv4 frames ending before 14+total_length bytes (saturating)
// BEHAVIOUR
// - Reset (async assert, sync-released use): m_axis_tvalid=0; tkeep/tdata/tlast=0; state=FIRST; counters=0.
// - Single registered output stage, latency 1 cycle. s_axis_tready = !m_axis_tvalid | m_axis_tready.
//   Output holds stable while m_axis_tvalid & !m_axis_tready.
// - States:
//   - FIRST: next accepted beat is a frame head.
//   - PASS: forward unchanged until tlast.
//   - TRIM: forward with length counting.
//   - DISCARD: accept and drop until input tlast; s_axis_tready=1, nothing is emitted.
// - Head decode on the first beat:
//   - etype = {byte12,byte13}; tl = {byte16,byte17}.
//   - If etype==16'h0800 & tl>=20 & EN_STRIP: rem = 14+tl (17-bit), else go PASS.
// - TRIM per beat, with kb = popcount(tkeep):
//   - rem>kb & !tlast: forward, rem -= kb, stay TRIM.
//   - rem>kb & tlast: forward unchanged, short_cnt++, go FIRST.
//   - rem==kb: forward unchanged with tlast forced to 1; go DISCARD if input !tlast, else FIRST.
//     trim_cnt++ only if input !tlast.
//   - rem<kb: tkeep = (1<<rem)-1, tlast=1, trim_cnt++; go DISCARD if input !tlast, else FIRST.
// - Every emitted beat has tkeep!=0. tdata is passed unmasked; bytes above tkeep are don't-care.
// - A single-beat input frame (tlast on head) is handled by the same rules in the same cycle.
// - Frames longer than 9600 B are not special-cased; rem is 17-bit, so there is no wrap.
// - Counters saturate at all-ones; no wrap.
// - Reset mid-frame: in-flight output beat is dropped. The next accepted beat is treated as a head; residual-beat misparse is tolerated.
// TESTING
// 1 IPv4 tl=28 (42 B) padded to 60 B, 1 beat keep=0x0FFF_FFFF_FFFF_FFFF
//   -> out keep=(1<<42)-1, tlast=1, trim_cnt=1.
// 2 IPv4 tl=1486 (1500 B), 24 beats, last keep=(1<<28)-1
//   -> output bit-identical, trim_cnt=0, short_cnt=0.
// 3 IPv4 tl=50 (64 B) followed by 1 extra garbage beat with tlast
//   -> 1 out beat keep=all-ones tlast=1; garbage beat swallowed; trim_cnt=1.
// 4 ARP etype 0x0806, 60 B -> passed unchanged, counters 0. IPv4 tl=100 but frame 60 B -> unchanged, short_cnt=1.
// 5 Back-to-back frames with random m_axis_tready (50%)
//   -> no beat lost/duplicated, data stable under stall, full throughput when tready=1.
// 6 Assert aresetn low mid-frame in TRIM
//   -> m_axis_tvalid=0 immediately; the next full frame is processed correctly.

Source files
------------

// File: rtl/network_rx_pad_strip.sv
// network_rx_pad_strip
// Removes Ethernet minimum-size padding from received frames. For IPv4 frames, tkeep and tlast
// are trimmed to exactly 14 + IPv4 total_length bytes, and any beats after that are dropped.
// All other frames pass through unchanged. There is one registered output stage, so latency is
// one cycle.
//
// Ports
//   aclk, aresetn        CMAC user clock (rclk domain), asynchronous active-low reset
//   s_axis_*             RX stream in (tvalid/tready/tdata/tkeep/tlast); byte 0 = tdata[7:0]
//   m_axis_*             RX stream out, same signal set
//   trim_cnt             frames whose keep/length was reduced (saturating)
//   short_cnt            IPv4 frames that ended before 14 + total_length bytes (saturating)
module network_rx_pad_strip #(
  parameter int unsigned DATA_BITS = 512,
  parameter int unsigned CNT_BITS  = 32,
  parameter bit          EN_STRIP  = 1'b1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_BITS-1:0]   m_axis_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [CNT_BITS-1:0]    trim_cnt,
  output logic [CNT_BITS-1:0]    short_cnt
);

  localparam int unsigned KeepBits = DATA_BITS / 8;
  localparam int unsigned KbW      = $clog2(KeepBits + 1);
  localparam int unsigned RemW     = 17;

  typedef enum logic [1:0] {StFirst, StPass, StTrim, StDiscard} state_e;

  state_e                state_q, state_d;
  logic [RemW-1:0]       rem_q, rem_d;
  logic                  valid_q, valid_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic [KeepBits-1:0]   keep_q, keep_d;
  logic                  last_q, last_d;
  logic [CNT_BITS-1:0]   trim_q, trim_d;
  logic [CNT_BITS-1:0]   short_q, short_d;

  logic                  out_ready, accept, do_trim, head_ipv4;
  logic                  trim_inc, short_inc;
  logic [15:0]           etype, tot_len;
  logic [KbW-1:0]        kb;
  logic [RemW-1:0]       kb_ext, rem_cur;
  logic [KeepBits-1:0]   trim_mask, out_keep;
  logic                  out_last;

  assign out_ready     = !valid_q || m_axis_tready;
  // Discarded beats never reach the output register, so they need no free output slot.
  assign s_axis_tready = (state_q == StDiscard) || out_ready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign etype     = {s_axis_tdata[103:96], s_axis_tdata[111:104]};
  assign tot_len   = {s_axis_tdata[135:128], s_axis_tdata[143:136]};
  assign head_ipv4 = EN_STRIP && (etype == 16'h0800) && (tot_len >= 16'd20);

  always_comb begin
    kb = '0;
    for (int i = 0; i < KeepBits; i++) begin
      kb = kb + KbW'(s_axis_tkeep[i]);
    end
  end

  assign kb_ext  = RemW'(kb);
  // On the head beat, the remaining count comes straight from the header, so one-beat frames
  // are trimmed in the same cycle they arrive.
  assign rem_cur = (state_q == StFirst) ? RemW'(tot_len) + RemW'(14) : rem_q;
  assign do_trim = (state_q == StTrim) || ((state_q == StFirst) && head_ipv4);
  // Only used when rem_cur < kb, so the shift stays within the keep width.
  assign trim_mask = ~({KeepBits{1'b1}} << rem_cur);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    valid_d   = valid_q;
    data_d    = data_q;
    keep_d    = keep_q;
    last_d    = last_q;
    out_keep  = s_axis_tkeep;
    out_last  = s_axis_tlast;
    trim_inc  = 1'b0;
    short_inc = 1'b0;

    if (out_ready) valid_d = 1'b0;

    if (accept) begin
      if (state_q == StDiscard) begin
        if (s_axis_tlast) state_d = StFirst;
      end else if (do_trim) begin
        if (rem_cur > kb_ext) begin
          if (s_axis_tlast) begin
            short_inc = 1'b1;
            state_d   = StFirst;
          end else begin
            rem_d   = rem_cur - kb_ext;
            state_d = StTrim;
          end
        end else begin
          out_last = 1'b1;
          if (rem_cur < kb_ext) out_keep = trim_mask;
          trim_inc = !s_axis_tlast || (rem_cur < kb_ext);
          state_d  = s_axis_tlast ? StFirst : StDiscard;
        end
      end else begin
        state_d = s_axis_tlast ? StFirst : StPass;
      end

      if (state_q != StDiscard) begin
        valid_d = 1'b1;
        data_d  = s_axis_tdata;
        keep_d  = out_keep;
        last_d  = out_last;
      end
    end

    trim_d  = (trim_inc && (trim_q != '1)) ? trim_q + 1'b1 : trim_q;
    short_d = (short_inc && (short_q != '1)) ? short_q + 1'b1 : short_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StFirst;
      rem_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      trim_q  <= '0;
      short_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      trim_q  <= trim_d;
      short_q <= short_d;
    end
  end

  assign m_axis_tvalid = valid_q;
  assign m_axis_tdata  = data_q;
  assign m_axis_tkeep  = keep_q;
  assign m_axis_tlast  = last_q;
  assign trim_cnt      = trim_q;
  assign short_cnt     = short_q;

endmodule

// File: tb/tb_network_rx_pad_strip.sv
module tb_network_rx_pad_strip;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic [31:0]  trim_cnt, short_cnt;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } beat_t;

  beat_t in_q[$];
  beat_t out_q[$];
  int    out_t[$];
  int    cyc = 0;
  int    n_pass = 0;
  int    n_total = 0;

  logic         stall_prev = 1'b0;
  logic [511:0] prev_d;
  logic [63:0]  prev_k;
  logic         prev_l;
  int           stab_err = 0;

  network_rx_pad_strip #(.DATA_BITS(512), .CNT_BITS(32), .EN_STRIP(1'b1)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .trim_cnt      (trim_cnt),
    .short_cnt     (short_cnt)
  );

  always #5 aclk = ~aclk;

  // Output capture and stall-stability watch.
  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (!aresetn) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev && !(m_axis_tvalid && m_axis_tdata === prev_d &&
                          m_axis_tkeep === prev_k && m_axis_tlast === prev_l))
        stab_err <= stab_err + 1;
      if (m_axis_tvalid && m_axis_tready) begin
        out_q.push_back('{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast});
        out_t.push_back(cyc);
      end
      stall_prev <= m_axis_tvalid && !m_axis_tready;
      prev_d     <= m_axis_tdata;
      prev_k     <= m_axis_tkeep;
      prev_l     <= m_axis_tlast;
    end
  end

  task automatic add_frame(input int nbytes, input logic [15:0] et, input logic [15:0] tl,
                           input logic [7:0] seed);
    beat_t      b;
    logic [7:0] v;
    int         nb;
    int         p;
    nb = (nbytes + 63) / 64;
    for (int i = 0; i < nb; i++) begin
      b.d = '0;
      b.k = '0;
      for (int j = 0; j < 64; j++) begin
        p = i * 64 + j;
        if (p < nbytes) begin
          v = seed + 8'(p);
          if (p == 12) v = et[15:8];
          if (p == 13) v = et[7:0];
          if (p == 16) v = tl[15:8];
          if (p == 17) v = tl[7:0];
          b.d[8*j +: 8] = v;
          b.k[j] = 1'b1;
        end
      end
      b.l = (i == nb - 1);
      in_q.push_back(b);
    end
  endtask

  // Drives every queued input beat, then lets the output drain.
  task automatic run_stream(input bit rnd, output int cycles, output bit timeout);
    bit hs;
    cycles = 0;
    while (in_q.size() > 0 && cycles < 5000) begin
      @(negedge aclk);
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = in_q[0].d;
      s_axis_tkeep  = in_q[0].k;
      s_axis_tlast  = in_q[0].l;
      #1;
      hs = s_axis_tready;
      @(posedge aclk);
      if (hs) void'(in_q.pop_front());
      cycles++;
    end
    timeout = (in_q.size() > 0);
    in_q.delete();
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (4) @(negedge aclk);
  endtask

  task automatic test_reset();
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge aclk);
    n_total++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tkeep !== '0 ||
        m_axis_tdata !== '0)
      $display("FAIL reset_out: got valid=%b last=%b keep=%h, expected 0/0/0",
               m_axis_tvalid, m_axis_tlast, m_axis_tkeep);
    else n_pass++;
    n_total++;
    if (trim_cnt !== 32'd0 || short_cnt !== 32'd0)
      $display("FAIL reset_cnt: got trim=%0d short=%0d, expected 0/0", trim_cnt, short_cnt);
    else n_pass++;
    n_total++;
    if (s_axis_tready !== 1'b1)
      $display("FAIL reset_ready: got %b, expected 1", s_axis_tready);
    else n_pass++;
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_pad_trim();
    beat_t snap[$];
    beat_t e;
    int    c;
    bit    to;
    out_q.delete();
    add_frame(60, 16'h0800, 16'd28, 8'h10);
    snap = in_q;
    run_stream(1'b0, c, to);
    e   = snap[0];
    e.k = 64'h0000_03FF_FFFF_FFFF;
    e.l = 1'b1;
    n_total++;
    if (to || out_q.size() != 1)
      $display("FAIL t1_count: got beats=%0d timeout=%b, expected 1/0", out_q.size(), to);
    else n_pass++;
    if (out_q.size() >= 1) begin
      n_total++;
      if (out_q[0].d !== e.d || out_q[0].k !== e.k || out_q[0].l !== e.l)
        $display("FAIL t1_beat: got keep=%h last=%b, expected keep=%h last=%b",
                 out_q[0].k, out_q[0].l, e.k, e.l);
      else n_pass++;
    end
    n_total++;
    if (trim_cnt !== 32'd1 || short_cnt !== 32'd0)
      $display("FAIL t1_cnt: got trim=%0d short=%0d, expected 1/0", trim_cnt, short_cnt);
    else n_pass++;
  endtask

  task automatic test_full_frame();
    beat_t snap[$];
    int    c;
    bit    to;
    out_q.delete();
    out_t.delete();
    add_frame(1500, 16'h0800, 16'd1486, 8'h33);
    snap = in_q;
    n_total++;
    if (snap[23].k !== 64'h0000_0000_0FFF_FFFF)
      $display("FAIL t2_stim: got last keep=%h, expected 0000000000fffffff", snap[23].k);
    else n_pass++;
    run_stream(1'b0, c, to);
    n_total++;
    if (to || out_q.size() != 24)
      $display("FAIL t2_count: got beats=%0d timeout=%b, expected 24/0", out_q.size(), to);
    else n_pass++;
    for (int i = 0; i < 24 && i < out_q.size(); i++) begin
      n_total++;
      if (out_q[i].d !== snap[i].d || out_q[i].k !== snap[i].k || out_q[i].l !== snap[i].l)
        $display("FAIL t2_beat%0d: got keep=%h last=%b, expected keep=%h last=%b", i,
                 out_q[i].k, out_q[i].l, snap[i].k, snap[i].l);
      else n_pass++;
    end
    n_total++;
    if (c != 24)
      $display("FAIL t2_in_rate: got %0d input cycles, expected 24", c);
    else n_pass++;
    if (out_t.size() == 24) begin
      n_total++;
      if (out_t[23] - out_t[0] != 23)
        $display("FAIL t2_out_rate: got span=%0d, expected 23", out_t[23] - out_t[0]);
      else n_pass++;
    end
    n_total++;
    if (trim_cnt !== 32'd1 || short_cnt !== 32'd0)
      $display("FAIL t2_cnt: got trim=%0d short=%0d, expected 1/0", trim_cnt, short_cnt);
    else n_pass++;
  endtask

  task automatic test_garbage();
    beat_t snap[$];
    beat_t e;
    int    c;
    bit    to;
    out_q.delete();
    add_frame(72, 16'h0800, 16'd50, 8'h5a);
    snap = in_q;
    run_stream(1'b0, c, to);
    e   = snap[0];
    e.l = 1'b1;
    n_total++;
    if (to || out_q.size() != 1)
      $display("FAIL t3_count: got beats=%0d timeout=%b, expected 1/0", out_q.size(), to);
    else n_pass++;
    if (out_q.size() >= 1) begin
      n_total++;
      if (out_q[0].d !== e.d || out_q[0].k !== 64'hFFFF_FFFF_FFFF_FFFF || out_q[0].l !== 1'b1)
        $display("FAIL t3_beat: got keep=%h last=%b, expected keep=ffffffffffffffff last=1",
                 out_q[0].k, out_q[0].l);
      else n_pass++;
    end
    n_total++;
    if (trim_cnt !== 32'd2 || short_cnt !== 32'd0)
      $display("FAIL t3_cnt: got trim=%0d short=%0d, expected 2/0", trim_cnt, short_cnt);
    else n_pass++;
  endtask

  task automatic test_arp_short();
    beat_t snap[$];
    int    c;
    bit    to;
    out_q.delete();
    add_frame(60, 16'h0806, 16'd28, 8'h71);
    snap = in_q;
    run_stream(1'b0, c, to);
    n_total++;
    if (to || out_q.size() != 1 || out_q[0].d !== snap[0].d || out_q[0].k !== snap[0].k ||
        out_q[0].l !== 1'b1)
      $display("FAIL t4_arp: got beats=%0d, expected 1 unchanged beat keep=%h", out_q.size(),
               snap[0].k);
    else n_pass++;
    n_total++;
    if (trim_cnt !== 32'd2 || short_cnt !== 32'd0)
      $display("FAIL t4_arp_cnt: got trim=%0d short=%0d, expected 2/0", trim_cnt, short_cnt);
    else n_pass++;
    out_q.delete();
    add_frame(60, 16'h0800, 16'd100, 8'h82);
    snap = in_q;
    run_stream(1'b0, c, to);
    n_total++;
    if (to || out_q.size() != 1 || out_q[0].d !== snap[0].d || out_q[0].k !== snap[0].k ||
        out_q[0].l !== 1'b1)
      $display("FAIL t4_short: got beats=%0d, expected 1 unchanged beat keep=%h", out_q.size(),
               snap[0].k);
    else n_pass++;
    n_total++;
    if (trim_cnt !== 32'd2 || short_cnt !== 32'd1)
      $display("FAIL t4_short_cnt: got trim=%0d short=%0d, expected 2/1", trim_cnt, short_cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    beat_t snap[$];
    beat_t exp_q[$];
    beat_t e;
    int    c;
    bit    to;
    out_q.delete();
    stab_err = 0;
    add_frame(60, 16'h0800, 16'd28, 8'h01);   // A: trimmed to 42 B
    add_frame(60, 16'h0806, 16'd46, 8'h02);   // B: ARP, unchanged
    add_frame(130, 16'h0800, 16'd116, 8'h03); // C: exact length, 3 beats
    add_frame(100, 16'h0800, 16'd20, 8'h04);  // D: 34 B kept, second beat dropped
    add_frame(60, 16'h0800, 16'd200, 8'h05);  // E: short frame
    snap = in_q;
    e = snap[0]; e.k = 64'h0000_03FF_FFFF_FFFF; exp_q.push_back(e);
    exp_q.push_back(snap[1]);
    exp_q.push_back(snap[2]);
    exp_q.push_back(snap[3]);
    exp_q.push_back(snap[4]);
    e = snap[5]; e.k = 64'h0000_0003_FFFF_FFFF; e.l = 1'b1; exp_q.push_back(e);
    exp_q.push_back(snap[7]);
    run_stream(1'b1, c, to);
    n_total++;
    if (to || out_q.size() != exp_q.size())
      $display("FAIL t5_count: got beats=%0d timeout=%b, expected %0d/0", out_q.size(), to,
               exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_total++;
      if (out_q[i].d !== exp_q[i].d || out_q[i].k !== exp_q[i].k || out_q[i].l !== exp_q[i].l)
        $display("FAIL t5_beat%0d: got keep=%h last=%b, expected keep=%h last=%b", i,
                 out_q[i].k, out_q[i].l, exp_q[i].k, exp_q[i].l);
      else n_pass++;
    end
    n_total++;
    if (stab_err != 0)
      $display("FAIL t5_stall_stable: got %0d unstable stalled cycles, expected 0", stab_err);
    else n_pass++;
    n_total++;
    if (trim_cnt !== 32'd4 || short_cnt !== 32'd2)
      $display("FAIL t5_cnt: got trim=%0d short=%0d, expected 4/2", trim_cnt, short_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    beat_t snap[$];
    beat_t e;
    int    c;
    bit    to;
    add_frame(1500, 16'h0800, 16'd1486, 8'h44);
    snap = in_q;
    in_q.delete();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = snap[i].d;
      s_axis_tkeep  = snap[i].k;
      s_axis_tlast  = snap[i].l;
    end
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    n_total++;
    if (m_axis_tvalid !== 1'b1)
      $display("FAIL t6_inflight: got valid=%b, expected 1", m_axis_tvalid);
    else n_pass++;
    aresetn = 1'b0;
    #1;
    n_total++;
    if (m_axis_tvalid !== 1'b0 || trim_cnt !== 32'd0 || short_cnt !== 32'd0)
      $display("FAIL t6_async: got valid=%b trim=%0d short=%0d, expected 0/0/0",
               m_axis_tvalid, trim_cnt, short_cnt);
    else n_pass++;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    out_q.delete();
    add_frame(60, 16'h0800, 16'd28, 8'h66);
    snap = in_q;
    run_stream(1'b0, c, to);
    e   = snap[0];
    e.k = 64'h0000_03FF_FFFF_FFFF;
    n_total++;
    if (to || out_q.size() != 1 || out_q[0].d !== e.d || out_q[0].k !== e.k ||
        out_q[0].l !== 1'b1)
      $display("FAIL t6_next_frame: got beats=%0d, expected 1 beat keep=%h", out_q.size(), e.k);
    else n_pass++;
    n_total++;
    if (trim_cnt !== 32'd1 || short_cnt !== 32'd0)
      $display("FAIL t6_cnt: got trim=%0d short=%0d, expected 1/0", trim_cnt, short_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pad_trim();
    test_full_frame();
    test_garbage();
    test_arp_short();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
